token_halver: RTL and testbench

Serial receive-side decoder for the doubled-token stream produced by the token doubler. Each pair of incoming `1` tokens on `b_in` is collapsed back into one output token on `a_out`, and a saturating count of decoded tokens is maintained. Two sticky error flags cover protocol violations:
- an over-long run of ones;
- an unpaired token left dangling across an idle gap.

The block sits at the consumer end of the serial token link.

---
 rtl/token_halver.sv | 106 ++++++++++
 tb/tb_token_halver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/token_halver.sv
// token_halver: collapses each pair of '1' tokens on b_in into one a_out pulse, with sticky
// overflow/unpaired error flags. Define TOKEN_HALVER_COUNT_EN to build the saturating token_count.
module token_halver #(
    parameter int MAX_RUN  = 400,
    parameter int IDLE_GAP = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b_in,
    output logic             a_out,
    output logic             overflow,
    output logic             unpaired,
    output logic [CNT_W-1:0] token_count
);
    localparam int RUN_W = $clog2(MAX_RUN + 2);
    localparam int GAP_W = $clog2(IDLE_GAP + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(IDLE_GAP);

    typedef enum logic [1:0] {ST_EVEN, ST_ODD, ST_ERROR} state_t;

    state_t           r_state, w_state_nxt;
    logic [RUN_W-1:0] r_run_cnt, w_run_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
    logic             r_a_out, r_overflow, r_unpaired;
    logic             w_pulse, w_set_ovf, w_set_unp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EVEN;
            r_run_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_a_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_unpaired <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_cnt  <= w_run_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_a_out    <= w_pulse;
            r_overflow <= r_overflow | w_set_ovf;
            r_unpaired <= r_unpaired | w_set_unp;
        end
    end

    // Overflow check precedes pairing, so the offending one never completes a pair.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_pulse     = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unp   = 1'b0;
        if (r_state != ST_ERROR) begin
            if (b_in) begin
                w_gap_nxt = '0;
                if (r_run_cnt == RUN_LIMIT) begin
                    w_set_ovf   = 1'b1;
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_run_nxt = r_run_cnt + 1'b1;
                    if (r_state == ST_ODD) begin
                        w_state_nxt = ST_EVEN;
                        w_pulse     = 1'b1;
                    end else begin
                        w_state_nxt = ST_ODD;
                    end
                end
            end else begin
                w_run_nxt = '0;
                if (r_state == ST_ODD) begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                    if (w_gap_nxt == GAP_LIMIT) begin
                        w_set_unp   = 1'b1;
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
        end
    end

    assign a_out    = r_a_out;
    assign overflow = r_overflow;
    assign unpaired = r_unpaired;

`ifdef TOKEN_HALVER_COUNT_EN
    logic [CNT_W-1:0] r_token_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // w_pulse is never raised in ST_ERROR, which freezes the count there.
    always_ff @(posedge clk) begin
        if (rst)
            r_token_count <= '0;
        else if (w_pulse)
            r_token_count <= sat_inc(r_token_count);
    end

    assign token_count = r_token_count;
`else
    assign token_count = '0;
`endif
endmodule

// File: tb/tb_token_halver.sv
// Directed bench for token_halver: default instance plus a CNT_W=3 instance for saturation.
module tb_token_halver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        b_in = 1'b0;
    logic        a_out, overflow, unpaired;
    logic [15:0] token_count;
    logic        a_out3, overflow3, unpaired3;
    logic [2:0]  token_count3;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    token_halver dut (
        .clk(clk), .rst(rst), .b_in(b_in),
        .a_out(a_out), .overflow(overflow), .unpaired(unpaired), .token_count(token_count)
    );

    token_halver #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .b_in(b_in),
        .a_out(a_out3), .overflow(overflow3), .unpaired(unpaired3), .token_count(token_count3)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n, input int w);
`ifdef TOKEN_HALVER_COUNT_EN
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input logic v);
        b_in = v;
        @(posedge clk);
        #1;
        if (a_out === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        b_in = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        pulses = 0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        b_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL reset_a_out: got %b want 0", a_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (unpaired !== 1'b0) begin errors++; $display("FAIL reset_unpaired: got %b want 0", unpaired); end
        checks++; if (token_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", token_count); end
        rst    = 1'b0;
        b_in   = 1'b0;
        pulses = 0;
    endtask

    task automatic test_example();
        logic [25:0] pat;
        pat = 26'b11011011110111111001111110;
        do_reset();
        for (int i = 25; i >= 0; i--) begin
            drive(pat[i]);
            if (i == 25) begin
                checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL ex_first_one: a_out got %b want 0", a_out); end
            end
            if (i == 24) begin
                checks++; if (a_out !== 1'b1) begin errors++; $display("FAIL ex_latency: a_out got %b want 1", a_out); end
            end
        end
        repeat (6) drive(1'b0);
        checks++; if (pulses != 10) begin errors++; $display("FAIL ex_pulses: got %0d want 10", pulses); end
        checks++; if (token_count !== 16'(exp_cnt(10, 16))) begin errors++; $display("FAIL ex_count: got %0d want %0d", token_count, exp_cnt(10, 16)); end
        checks++; if (overflow !== 1'b0 || unpaired !== 1'b0) begin errors++; $display("FAIL ex_flags: got ovf=%b unp=%b want 0 0", overflow, unpaired); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            got[i] = a_out;
        end
        checks++; if (got !== 4'b1010) begin errors++; $display("FAIL b2b_pattern: got %b want 1010", got); end
        drive(1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (400) drive(1'b1);
        drive(1'b0);
        checks++; if (pulses != 200) begin errors++; $display("FAIL run400_pulses: got %0d want 200", pulses); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL run400_overflow: got %b want 0", overflow); end
        do_reset();
        repeat (400) drive(1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL run401_early: overflow got %b want 0", overflow); end
        drive(1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL run401_overflow: got %b want 1", overflow); end
        checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL run401_nopulse: a_out got %b want 0", a_out); end
        repeat (6) drive(1'b1);
        repeat (3) drive(1'b0);
        checks++; if (pulses != 200) begin errors++; $display("FAIL run401_pulses: got %0d want 200", pulses); end
        checks++; if (token_count !== 16'(exp_cnt(200, 16))) begin errors++; $display("FAIL run401_count: got %0d want %0d", token_count, exp_cnt(200, 16)); end
        checks++; if (overflow !== 1'b1 || unpaired !== 1'b0) begin errors++; $display("FAIL run401_sticky: got ovf=%b unp=%b want 1 0", overflow, unpaired); end
    endtask

    task automatic test_gap_pair();
        do_reset();
        drive(1'b1);
        repeat (3) drive(1'b0);
        drive(1'b1);
        checks++; if (a_out !== 1'b1) begin errors++; $display("FAIL gap3_pulse: a_out got %b want 1", a_out); end
        drive(1'b0);
        checks++; if (unpaired !== 1'b0) begin errors++; $display("FAIL gap3_unpaired: got %b want 0", unpaired); end
    endtask

    task automatic test_unpaired_sticky();
        do_reset();
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        repeat (3) drive(1'b0);
        checks++; if (unpaired !== 1'b0) begin errors++; $display("FAIL unp_early: got %b want 0", unpaired); end
        drive(1'b0);
        checks++; if (unpaired !== 1'b1) begin errors++; $display("FAIL unp_set: got %b want 1", unpaired); end
        drive(1'b1);
        drive(1'b1);
        checks++; if (pulses != 1) begin errors++; $display("FAIL unp_nopulse: pulses got %0d want 1", pulses); end
        for (int i = 0; i < 50; i++) drive(logic'(i[0]));
        checks++; if (pulses != 1) begin errors++; $display("FAIL unp_toggle_pulses: got %0d want 1", pulses); end
        checks++; if (unpaired !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL unp_toggle_flags: got unp=%b ovf=%b want 1 0", unpaired, overflow); end
        checks++; if (token_count !== 16'(exp_cnt(1, 16))) begin errors++; $display("FAIL unp_toggle_count: got %0d want %0d", token_count, exp_cnt(1, 16)); end
        do_reset();
        checks++; if (unpaired !== 1'b0 || overflow !== 1'b0 || a_out !== 1'b0 || token_count !== 16'd0) begin
            errors++; $display("FAIL unp_reset: got unp=%b ovf=%b a=%b cnt=%0d want all 0", unpaired, overflow, a_out, token_count);
        end
        drive(1'b1);
        drive(1'b1);
        checks++; if (a_out !== 1'b1) begin errors++; $display("FAIL unp_after_rst_pulse: got %b want 1", a_out); end
        checks++; if (token_count !== 16'(exp_cnt(1, 16))) begin errors++; $display("FAIL unp_after_rst_count: got %0d want %0d", token_count, exp_cnt(1, 16)); end
    endtask

    task automatic test_mid_pair_reset();
        do_reset();
        drive(1'b1);
        do_reset();
        drive(1'b1);
        checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL midrst_nopulse: a_out got %b want 0", a_out); end
        drive(1'b1);
        checks++; if (a_out !== 1'b1) begin errors++; $display("FAIL midrst_pair: a_out got %b want 1", a_out); end
        drive(1'b1);
        rst  = 1'b1;
        b_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL rst_inflight: a_out got %b want 0", a_out); end
        drive(1'b1);
        checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL rst_newstream: a_out got %b want 0", a_out); end
        drive(1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 18; i++) begin
            drive(1'b1);
            if (i == 12) begin
                checks++; if (token_count3 !== 3'(exp_cnt(6, 3))) begin errors++; $display("FAIL sat_6: got %0d want %0d", token_count3, exp_cnt(6, 3)); end
            end
            if (i == 14) begin
                checks++; if (token_count3 !== 3'(exp_cnt(7, 3))) begin errors++; $display("FAIL sat_7: got %0d want %0d", token_count3, exp_cnt(7, 3)); end
            end
        end
        checks++; if (a_out3 !== 1'b1) begin errors++; $display("FAIL sat_pulse: a_out got %b want 1", a_out3); end
        checks++; if (token_count3 !== 3'(exp_cnt(9, 3))) begin errors++; $display("FAIL sat_hold: got %0d want %0d", token_count3, exp_cnt(9, 3)); end
        checks++; if (token_count !== 16'(exp_cnt(9, 16))) begin errors++; $display("FAIL sat_wide: got %0d want %0d", token_count, exp_cnt(9, 16)); end
        drive(1'b0);
    endtask

    initial begin
        test_reset();
        test_example();
        test_back_to_back();
        test_overflow();
        test_gap_pair();
        test_unpaired_sticky();
        test_mid_pair_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
